mem_port_arbiter: RTL and testbench

//  Shares one single-port unified memory between the pipeline's instruction-fetch side (I) and data side (D).

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/arb_grant.sv | 46 ++++
 rtl/mem_port_arbiter.sv | 114 +++++++++++
 tb/tb_mem_port_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared encodings for the I/D unified-memory port arbiter.
package mem_arb_pkg;

  // Arbiter FSM state encoding
  typedef logic [1:0] arbState_t;

  localparam arbState_t S_IDLE = 2'd0;
  localparam arbState_t S_IACC = 2'd1;
  localparam arbState_t S_DACC = 2'd2;
  localparam arbState_t S_RESP = 2'd3;

  // Owner of the current memory access
  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  // Byte-offset bits dropped to form a word address
  localparam int unsigned BYTE_OFS_W = 2;

endpackage

// File: rtl/arb_grant.sv
// Next-owner decision for the I/D arbiter plus the starvation counter that
// bounds how many consecutive D wins a waiting fetch can suffer.
module arb_grant
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic iReq,
  input  logic dReq,
  input  logic arbEn,
  output logic grantValid_c,
  output logic grantOwner_c
);

  localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);

  logic [CW-1:0] starveCnt;
  logic          starved;

  assign starved = iReq && (starveCnt == CW'(STARVE_LIMIT));

  // Fixed priority to D unless a waiting fetch has hit the starvation limit
  always_comb begin
    grantValid_c = iReq || dReq;
    grantOwner_c = OWN_I;
    if (dReq && !starved) begin
      grantOwner_c = OWN_D;
    end
  end

  // Saturating count of D wins taken while a fetch was waiting
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starveCnt <= '0;
    end else if (arbEn && grantValid_c) begin
      if (grantOwner_c == OWN_I) begin
        starveCnt <= '0;
      end else if (iReq && (starveCnt != CW'(STARVE_LIMIT))) begin
        starveCnt <= starveCnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch (I) and the data
// side (D). D has priority; a starvation counter forces an I grant eventually.
// The mem_* outputs double as the grant latch so they stay stable during an access.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW           = 32,
  parameter int unsigned DW           = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  output logic          i_ack,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ack,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready
);

  arbState_t state;
  logic      owner;
  logic      arbEn_c;
  logic      grantValid_c;
  logic      grantOwner_c;
  logic      unusedAddrBits;

  // Byte offsets are irrelevant to a word-wide memory
  assign unusedAddrBits = ^{i_addr[BYTE_OFS_W-1:0], d_addr[BYTE_OFS_W-1:0]};

  assign arbEn_c = (state == S_IDLE);

  arb_grant #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) uGrant (
    .clk          (clk),
    .reset        (reset),
    .iReq         (i_req),
    .dReq         (d_req),
    .arbEn        (arbEn_c),
    .grantValid_c (grantValid_c),
    .grantOwner_c (grantOwner_c)
  );

  // Arbitration FSM with grant latch, read-data capture and ack pulses
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      owner     <= OWN_I;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      i_rdata   <= '0;
      d_rdata   <= '0;
      i_ack     <= 1'b0;
      d_ack     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grantValid_c) begin
            owner   <= grantOwner_c;
            mem_req <= 1'b1;
            if (grantOwner_c == OWN_D) begin
              state     <= S_DACC;
              mem_we    <= d_we;
              mem_addr  <= {d_addr[AW-1:BYTE_OFS_W], BYTE_OFS_W'(0)};
              mem_wdata <= d_wdata;
            end else begin
              state     <= S_IACC;
              mem_we    <= 1'b0;
              mem_addr  <= {i_addr[AW-1:BYTE_OFS_W], BYTE_OFS_W'(0)};
              mem_wdata <= '0;
            end
          end
        end
        S_IACC, S_DACC: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
            state   <= S_RESP;
            if (owner == OWN_I) begin
              i_rdata <= mem_rdata;
              i_ack   <= 1'b1;
            end else begin
              d_ack <= 1'b1;
              if (!mem_we) begin
                d_rdata <= mem_rdata;
              end
            end
          end
        end
        S_RESP: begin
          i_ack <= 1'b0;
          d_ack <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, multi-cycle
// corner sequences, then random traffic against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int unsigned LIMIT = 4;

  logic        clk;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_ack;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  int errCnt = 0;
  int chkCnt = 0;

  mem_port_arbiter #(
    .AW           (32),
    .DW           (32),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_rdata   (i_rdata),
    .i_ack     (i_ack),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_ack     (d_ack),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    chkCnt++;
    if (act !== exp) begin
      errCnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          isD;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] memData;
    int          waits;
    logic [31:0] expMemAddr;
    bit          expMemWe;
    logic [31:0] expMemWdata;
    logic [31:0] expIRdata;
    logic [31:0] expDRdata;
  } vec_t;

  vec_t vecs[6];
  vec_t postResetVec;

  // One access from an idle arbiter; spurious mem_ready is driven during the ack cycle
  task automatic doAccess(input vec_t v, input string tag);
    if (v.isD) begin
      d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
    end else begin
      i_req = 1'b1; i_addr = v.addr;
    end
    mem_rdata = v.memData;
    for (int c = 0; c <= v.waits; c++) begin
      @(negedge clk);
      chk({tag, " mem_req"}, 64'(mem_req), 64'(1));
      chk({tag, " mem_addr"}, 64'(mem_addr), 64'(v.expMemAddr));
      chk({tag, " mem_we"}, 64'(mem_we), 64'(v.expMemWe));
      chk({tag, " mem_wdata"}, 64'(mem_wdata), 64'(v.expMemWdata));
      chk({tag, " early ack"}, 64'({i_ack, d_ack}), 64'(0));
      if (c == v.waits) mem_ready = 1'b1;
    end
    @(negedge clk);
    chk({tag, " mem_req drop"}, 64'(mem_req), 64'(0));
    chk({tag, " i_ack"}, 64'(i_ack), 64'(!v.isD));
    chk({tag, " d_ack"}, 64'(d_ack), 64'(v.isD));
    chk({tag, " i_rdata"}, 64'(i_rdata), 64'(v.expIRdata));
    chk({tag, " d_rdata"}, 64'(d_rdata), 64'(v.expDRdata));
    i_req = 1'b0; d_req = 1'b0;
    mem_ready = 1'b1; mem_rdata = ~v.memData;
    @(negedge clk);
    chk({tag, " ack pulse"}, 64'({i_ack, d_ack}), 64'(0));
    chk({tag, " idle mem_req"}, 64'(mem_req), 64'(0));
    chk({tag, " i_rdata hold"}, 64'(i_rdata), 64'(v.expIRdata));
    chk({tag, " d_rdata hold"}, 64'(d_rdata), 64'(v.expDRdata));
    mem_ready = 1'b0;
  endtask

  task automatic pulseReset();
    i_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0;
    #2 reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  // Random-phase model state
  bit [31:0]   memArr [int unsigned];
  bit          inFlight, prevIdle, readyLast, ackNow, gD, gWe, memActive;
  int          streak, lat, ackIdx;
  logic [31:0] gAddr, gWdata, rdLast, expIR, expDR;
  bit          expD;

  initial begin
    vecs[0] = '{0, 0, 32'h0000_0013, 32'h0, 32'h2008_0005, 0, 32'h0000_0010, 0, 32'h0,
                32'h2008_0005, 32'h0};
    vecs[1] = '{1, 1, 32'h0000_0054, 32'hDEAD_BEEF, 32'h1111_1111, 3, 32'h0000_0054, 1,
                32'hDEAD_BEEF, 32'h2008_0005, 32'h0};
    vecs[2] = '{1, 0, 32'h0000_1003, 32'h0BAD_0BAD, 32'hCAFE_F00D, 1, 32'h0000_1000, 0,
                32'h0BAD_0BAD, 32'h2008_0005, 32'hCAFE_F00D};
    vecs[3] = '{0, 0, 32'hFFFF_FFFE, 32'h0, 32'h1234_5678, 2, 32'hFFFF_FFFC, 0, 32'h0,
                32'h1234_5678, 32'hCAFE_F00D};
    vecs[4] = '{1, 1, 32'h0000_0007, 32'h0000_A5A5, 32'h5555_5555, 0, 32'h0000_0004, 1,
                32'h0000_A5A5, 32'h1234_5678, 32'hCAFE_F00D};
    vecs[5] = '{1, 0, 32'h0000_0008, 32'h0, 32'h0, 0, 32'h0000_0008, 0, 32'h0,
                32'h1234_5678, 32'h0};
    postResetVec = '{0, 0, 32'h0000_0104, 32'h0, 32'h7777_0001, 1, 32'h0000_0104, 0, 32'h0,
                     32'h7777_0001, 32'h0};

    // Reset held with both requesters active
    reset = 1'b1; i_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
    d_addr = 32'h0000_0101; d_wdata = 32'h0; i_addr = 32'h0000_0200;
    mem_ready = 1'b0; mem_rdata = 32'h0;
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst mem_req", 64'(mem_req), 64'(0));
    chk("rst mem_we", 64'(mem_we), 64'(0));
    chk("rst mem_addr", 64'(mem_addr), 64'(0));
    chk("rst mem_wdata", 64'(mem_wdata), 64'(0));
    chk("rst i_rdata", 64'(i_rdata), 64'(0));
    chk("rst d_rdata", 64'(d_rdata), 64'(0));
    chk("rst acks", 64'({i_ack, d_ack}), 64'(0));
    reset = 1'b1;
    @(negedge clk);
    chk("rst first grant mem_req", 64'(mem_req), 64'(1));
    chk("rst first grant is D", 64'(mem_addr), 64'(32'h0000_0100));
    pulseReset();

    // Directed vector table
    for (int k = 0; k < 6; k++) begin
      doAccess(vecs[k], $sformatf("vec%0d", k));
    end

    // Spurious mem_ready while idle
    mem_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      mem_rdata = $urandom;
      @(negedge clk);
      chk("idle ready mem_req", 64'(mem_req), 64'(0));
      chk("idle ready acks", 64'({i_ack, d_ack}), 64'(0));
      chk("idle ready i_rdata", 64'(i_rdata), 64'(32'h1234_5678));
      chk("idle ready d_rdata", 64'(d_rdata), 64'(32'h0));
    end
    mem_ready = 1'b0;

    // Contention with a zero-wait memory
    pulseReset();
    i_req = 1'b1; i_addr = 32'h0000_0090;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0080;
    mem_ready = 1'b1; mem_rdata = 32'h0000_0042;
    ackIdx = 0;
    for (int cyc = 0; cyc < 80 && ackIdx < 10; cyc++) begin
      @(negedge clk);
      if (i_ack || d_ack) begin
        expD = (ackIdx % (LIMIT + 1)) != LIMIT;
        chk($sformatf("contention grant%0d d_ack", ackIdx), 64'(d_ack), 64'(expD));
        chk($sformatf("contention grant%0d i_ack", ackIdx), 64'(i_ack), 64'(!expD));
        if (i_ack) begin
          chk("contention starve after I", 64'(dut.uGrant.starveCnt), 64'(0));
        end else begin
          chk("contention starve after D", 64'(dut.uGrant.starveCnt),
              64'((ackIdx % (LIMIT + 1)) + 1));
        end
        ackIdx++;
      end
    end
    chk("contention ack count", 64'(ackIdx), 64'(10));
    i_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0;
    repeat (2) @(negedge clk);

    // Reset arriving during a D access
    pulseReset();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0040;
    @(negedge clk);
    chk("midrst mem_req up", 64'(mem_req), 64'(1));
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("midrst mem_req async drop", 64'(mem_req), 64'(0));
    d_req = 1'b0; mem_ready = 1'b1;
    @(negedge clk);
    chk("midrst no d_ack", 64'(d_ack), 64'(0));
    reset = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("midrst no ack after", 64'({i_ack, d_ack}), 64'(0));
      chk("midrst d_rdata clear", 64'(d_rdata), 64'(0));
    end
    mem_ready = 1'b0;
    doAccess(postResetVec, "postrst");

    // Random traffic against a transaction-level model
    pulseReset();
    inFlight = 0; prevIdle = 1; readyLast = 0; streak = 0; memActive = 0; lat = 0;
    expIR = 32'h0; expDR = 32'h0; gD = 0; gWe = 0; gAddr = 0; gWdata = 0; rdLast = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      ackNow = 0;
      if (inFlight && readyLast) begin
        chk("rnd mem_req drop", 64'(mem_req), 64'(0));
        chk("rnd i_ack", 64'(i_ack), 64'(!gD));
        chk("rnd d_ack", 64'(d_ack), 64'(gD));
        if (!gD) expIR = rdLast;
        else if (!gWe) expDR = rdLast;
        inFlight = 0;
        ackNow = 1;
      end else begin
        if (!inFlight && prevIdle && (i_req || d_req)) begin
          gD = d_req && !(i_req && streak >= int'(LIMIT));
          if (gD) begin
            if (i_req) streak++;
            gWe = d_we; gAddr = d_addr & ~32'h3; gWdata = d_wdata;
          end else begin
            streak = 0;
            gWe = 0; gAddr = i_addr & ~32'h3; gWdata = 32'h0;
          end
          inFlight = 1;
        end
        chk("rnd mem_req", 64'(mem_req), 64'(inFlight));
        if (inFlight) begin
          chk("rnd mem_addr", 64'(mem_addr), 64'(gAddr));
          chk("rnd mem_we", 64'(mem_we), 64'(gWe));
          chk("rnd mem_wdata", 64'(mem_wdata), 64'(gWdata));
        end
        chk("rnd no ack", 64'({i_ack, d_ack}), 64'(0));
      end
      chk("rnd i_rdata", 64'(i_rdata), 64'(expIR));
      chk("rnd d_rdata", 64'(d_rdata), 64'(expDR));
      prevIdle = !inFlight && !ackNow;

      // Memory: random 0..3 wait states, spurious ready while not accessed
      readyLast = 0;
      if (mem_req && inFlight) begin
        if (!memActive) begin
          memActive = 1;
          lat = $urandom_range(0, 3);
        end
        if (lat == 0) begin
          rdLast = memArr.exists(gAddr >> 2) ? memArr[gAddr >> 2] : 32'h0;
          if (gWe) memArr[gAddr >> 2] = gWdata;
          mem_ready = 1'b1;
          mem_rdata = rdLast;
          memActive = 0;
          readyLast = 1;
        end else begin
          lat--;
          mem_ready = 1'b0;
          mem_rdata = $urandom;
        end
      end else begin
        memActive = 0;
        mem_ready = ($urandom_range(0, 3) == 0);
        mem_rdata = $urandom;
      end

      // Requesters: drop on ack, otherwise occasionally start a new access
      if (ackNow && !gD) i_req = 1'b0;
      else if (!i_req && $urandom_range(0, 2) == 0) begin
        i_req = 1'b1;
        i_addr = 32'($urandom_range(0, 255));
      end
      if (ackNow && gD) d_req = 1'b0;
      else if (!d_req && $urandom_range(0, 2) == 0) begin
        d_req = 1'b1;
        d_we = 1'($urandom_range(0, 1));
        d_addr = 32'($urandom_range(0, 255));
        d_wdata = $urandom;
      end
    end

    $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
    $finish;
  end

endmodule
